uart_tx_sched: RTL and testbench
================================

// Module: uart_tx_sched
// PURPOSE
//  Transmit-side controller for the UART. Captures core CSR writes to FifoWordCsrAddr ('h50, 4 bytes)
//  and FifoByteCsrAddr ('h51, 1 byte) into a byte-wide circular queue. Drains the queue through an
//  8N1 serializer paced by a baud counter. Sits between the CSR write bus and the tx pin.
// PARAMETERS
//  QueueSize  256        queue depth in bytes; power of two, >= 4
//  CmpVal     173        clock cycles per bit (CoreFreq / UartBaudRate = 20000000 / 115200); >= 2
//  WordAddr   'h50       CSR address for a 4-byte push
//  ByteAddr   'h51       CSR address for a 1-byte push
// PORTS
//  clk           in   1                 core clock
//  reset         in   1                 synchronous, active-high
//  csr_enable    in   1                 CSR write strobe; one push per asserted cycle
//  csr_addr      in   12                CSR address
//  csr_data      in   32                CSR write data
//  overflow_clr  in   1                 clears the sticky overflow flag
//  tx            out  1                 serial line, idle high
//  busy          out  1                 high while a frame is on the line
//  level         out  $clog2(QueueSize)+1  bytes queued, excluding the byte in flight
//  full          out  1                 level == QueueSize
//  overflow      out  1                 sticky: a push was dropped
// BEHAVIOUR
//  Reset: tx=1, busy=0, level=0, full=0, overflow=0; read/write pointers=0; FSM=IDLE; baud and bit counters=0.
//   A reset mid-frame aborts the frame: tx is high on the next cycle and the queue is emptied.
//  Push (a CSR write whose address does not match WordAddr or ByteAddr is ignored):
//   - Word: csr_enable && csr_addr==WordAddr. Accepted only if free space (QueueSize-level) >= 4.
//     Bytes are written in the order csr_data[7:0], [15:8], [23:16], [31:24]; wptr += 4.
//   - Byte: csr_enable && csr_addr==ByteAddr. Accepted only if level < QueueSize; csr_data[7:0] is
//     written; wptr += 1.
//   - A rejected push writes nothing, leaves the pointers unchanged, and sets overflow on the next edge.
//     A word is never partially accepted.
//  Pointers wrap modulo QueueSize. level is updated every edge as level + pushed - popped.
//   A push and a pop in the same cycle are both applied; space for the push is judged on the pre-edge level.
//  overflow: set-priority. If overflow_clr and a rejected push occur in the same cycle, overflow stays set.
//  FSM states: IDLE, START, DATA, STOP. Each bit lasts exactly CmpVal cycles, counted by the baud counter 0..CmpVal-1.
//   - IDLE: tx=1, busy=0. If level>0: pop queue[rptr] into the shift register, rptr+=1, go to START.
//   - START: tx=0, busy=1. At the end of the bit, go to DATA with bit index 0.
//   - DATA: tx=shift[0], LSB first. At the end of each bit, shift right; after the 8th bit, go to STOP.
//   - STOP: tx=1. At the end of the bit: if level>0, pop and go directly to START (no idle gap);
//     otherwise go to IDLE.
//  tx and busy are registered. Latency: for a push accepted at edge E0 into an empty idle queue, the FSM
//   pops at E1 and tx falls after E1.
//  A frame is 10*CmpVal cycles. A back-to-back stream keeps busy high continuously.
//  A push that arrives while the queue is empty and a frame is in STOP is popped at the end of STOP.
// CONFIGURATION
//  UART_TX_IRQ_EN defined: adds output tx_empty_irq (1 bit, reset 0). It is a one-cycle pulse on the edge
//   where the FSM enters IDLE from STOP with level==0, signalling that the queue drained and the line is idle.
//   Intended for an N-CLIC vector input.
//  UART_TX_IRQ_EN undefined: the port and its logic are absent; all other behaviour is identical.
// TESTING  (bench uses CmpVal=4, QueueSize=8)
//  1 Byte write 'h55 to 'h51 -> tx falls 2 edges later. tx then shows 0,1,0,1,0,1,0,1,0,1 over 10 bits of
//    4 cycles each. Then busy=0 and level=0.
//  2 Word write 'h44332211 to 'h50 -> bytes 'h11,'h22,'h33,'h44 leave in that order, back-to-back, with
//    busy high for 160 contiguous cycles.
//  3 Queue filled with 8 bytes while idle, then a byte write -> overflow=1 and level unchanged. A pulse on
//    overflow_clr -> overflow=0.
//  4 level=5, word write -> rejected whole (level stays 5, overflow=1). In the same cycle as a pop at
//    level=8, a byte write -> accepted only after level has dropped; in that cycle it is rejected.
//  5 Write 12 bytes in bursts across a pointer wrap -> the output byte sequence equals the input sequence.
//  6 reset asserted mid-DATA -> tx=1 and busy=0 on the next cycle, level=0, and no further frames.
//    With UART_TX_IRQ_EN, scenario 1 yields exactly one tx_empty_irq pulse, at the end of the frame.

Source files
------------

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: captures CSR pushes into a byte queue and drains it through an 8N1 serializer.
// Define UART_TX_IRQ_EN to add tx_empty_irq, a pulse when the queue has drained and the line goes idle.
module uart_tx_sched #(
    parameter int unsigned QueueSize = 256,
    parameter int unsigned CmpVal    = 173,
    parameter logic [11:0] WordAddr  = 12'h50,
    parameter logic [11:0] ByteAddr  = 12'h51
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         csr_enable,
    input  logic [11:0]                  csr_addr,
    input  logic [31:0]                  csr_data,
    input  logic                         overflow_clr,
    output logic                         tx,
    output logic                         busy,
    output logic [$clog2(QueueSize):0]   level,
    output logic                         full,
    output logic                         overflow
`ifdef UART_TX_IRQ_EN
    ,
    output logic                         tx_empty_irq
`endif
);

    localparam int unsigned PtrW   = $clog2(QueueSize);
    localparam int unsigned LevelW = PtrW + 1;
    localparam int unsigned CntW   = $clog2(CmpVal);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } txStateT;

    logic [7:0]        queueMem [QueueSize];
    logic [PtrW-1:0]   wPtr;
    logic [PtrW-1:0]   rPtr;
    txStateT           state;
    logic [CntW-1:0]   baudCnt;
    logic [2:0]        bitIdx;
    logic [7:0]        shiftReg;

    logic              wordReq;
    logic              byteReq;
    logic              wordOk;
    logic              byteOk;
    logic              pushWord;
    logic              pushByte;
    logic              pushReject;
    logic              baudEnd;
    logic              popNow;
    logic [LevelW-1:0] freeSpace;
    logic [LevelW-1:0] pushCnt;
    logic [LevelW-1:0] levelNext;

    // Push acceptance and pop decisions, all judged on the pre-edge level.
    always_comb begin
        wordReq    = csr_enable && (csr_addr == WordAddr);
        byteReq    = csr_enable && (csr_addr == ByteAddr);
        freeSpace  = LevelW'(QueueSize) - level;
        wordOk     = freeSpace >= LevelW'(4);
        byteOk     = level < LevelW'(QueueSize);
        pushWord   = wordReq && wordOk;
        pushByte   = byteReq && byteOk;
        pushReject = (wordReq && !wordOk) || (byteReq && !byteOk);
        pushCnt    = pushWord ? LevelW'(4) : (pushByte ? LevelW'(1) : LevelW'(0));
        baudEnd    = baudCnt == CntW'(CmpVal - 1);
        popNow     = (level != LevelW'(0)) && ((state == IDLE) || ((state == STOP) && baudEnd));
        levelNext  = level + pushCnt - LevelW'(popNow);
    end

    // Queue storage; a word lands little-endian at consecutive wrapped slots.
    always_ff @(posedge clk) begin
        if (pushWord) begin
            for (int k = 0; k < 4; k++) begin
                queueMem[wPtr + PtrW'(k)] <= csr_data[8*k +: 8];
            end
        end else if (pushByte) begin
            queueMem[wPtr] <= csr_data[7:0];
        end
    end

    // Pointers, occupancy and the sticky overflow flag (set wins over clear).
    always_ff @(posedge clk) begin
        if (reset) begin
            wPtr     <= '0;
            rPtr     <= '0;
            level    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (pushWord) begin
                wPtr <= wPtr + PtrW'(4);
            end else if (pushByte) begin
                wPtr <= wPtr + PtrW'(1);
            end
            if (popNow) begin
                rPtr <= rPtr + PtrW'(1);
            end
            level <= levelNext;
            full  <= levelNext == LevelW'(QueueSize);
            if (pushReject) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Serializer FSM; tx and busy are loaded with the value for the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baudCnt  <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
`ifdef UART_TX_IRQ_EN
            tx_empty_irq <= 1'b0;
`endif
        end else begin
`ifdef UART_TX_IRQ_EN
            tx_empty_irq <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    tx      <= 1'b1;
                    busy    <= 1'b0;
                    baudCnt <= '0;
                    if (popNow) begin
                        shiftReg <= queueMem[rPtr];
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (baudEnd) begin
                        baudCnt <= '0;
                        bitIdx  <= '0;
                        tx      <= shiftReg[0];
                        state   <= DATA;
                    end else begin
                        baudCnt <= baudCnt + CntW'(1);
                    end
                end
                DATA: begin
                    if (baudEnd) begin
                        baudCnt <= '0;
                        if (bitIdx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bitIdx   <= bitIdx + 3'd1;
                            shiftReg <= {1'b0, shiftReg[7:1]};
                            tx       <= shiftReg[1];
                        end
                    end else begin
                        baudCnt <= baudCnt + CntW'(1);
                    end
                end
                STOP: begin
                    if (baudEnd) begin
                        baudCnt <= '0;
                        if (popNow) begin
                            // Back-to-back: next start bit follows the stop bit with no idle gap.
                            shiftReg <= queueMem[rPtr];
                            tx       <= 1'b0;
                            state    <= START;
                        end else begin
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
`ifdef UART_TX_IRQ_EN
                            tx_empty_irq <= 1'b1;
`endif
                        end
                    end else begin
                        baudCnt <= baudCnt + CntW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: queue/line behavioural model compared every cycle, directed scenarios plus random traffic.
module tb_uart_tx_sched;

    localparam int unsigned QS       = 8;
    localparam int unsigned C        = 4;
    localparam int unsigned FrameLen = 10 * C;

    logic        clk = 1'b0;
    logic        reset;
    logic        csr_enable;
    logic [11:0] csr_addr;
    logic [31:0] csr_data;
    logic        overflow_clr;
    logic        tx;
    logic        busy;
    logic [3:0]  level;
    logic        full;
    logic        overflow;
`ifdef UART_TX_IRQ_EN
    logic        tx_empty_irq;
    int          irqCnt = 0;
`endif

    uart_tx_sched #(
        .QueueSize (QS),
        .CmpVal    (C),
        .WordAddr  (12'h50),
        .ByteAddr  (12'h51)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .csr_enable   (csr_enable),
        .csr_addr     (csr_addr),
        .csr_data     (csr_data),
        .overflow_clr (overflow_clr),
        .tx           (tx),
        .busy         (busy),
        .level        (level),
        .full         (full),
        .overflow     (overflow)
`ifdef UART_TX_IRQ_EN
        ,
        .tx_empty_irq (tx_empty_irq)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit checkEn = 0;

    // Behavioural model: a byte queue plus a frame timer counting cycles since the start bit.
    logic [7:0] mq[$];
    logic [7:0] mSent[$];
    bit         mActive = 0;
    int         mPos = 0;
    logic [7:0] mCur = 8'h00;
    bit         mOvf = 0;
    bit         mIrq = 0;
    int         mLvl;
    bit         mEnd;
    bit         mPop;
    bit         mRej;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            mActive = 0;
            mPos = 0;
            mOvf = 0;
            mIrq = 0;
        end else begin
            mLvl = mq.size();
            mEnd = mActive && (mPos == FrameLen - 1);
            mPop = (mLvl > 0) && (!mActive || mEnd);
            mIrq = mEnd && (mLvl == 0);
            mRej = 0;
            if (mPop) begin
                mCur = mq.pop_front();
                mSent.push_back(mCur);
            end
            if (csr_enable && csr_addr == 12'h50) begin
                if (QS - mLvl >= 4) begin
                    for (int k = 0; k < 4; k++) mq.push_back(csr_data[8*k +: 8]);
                end else mRej = 1;
            end else if (csr_enable && csr_addr == 12'h51) begin
                if (mLvl < QS) mq.push_back(csr_data[7:0]);
                else mRej = 1;
            end
            if (mRej) mOvf = 1;
            else if (overflow_clr) mOvf = 0;
            if (mPop) begin
                mActive = 1;
                mPos = 0;
            end else if (mEnd) begin
                mActive = 0;
                mPos = 0;
            end else if (mActive) begin
                mPos++;
            end
        end
    end

    function automatic logic expTx();
        int b;
        if (!mActive) return 1'b1;
        b = mPos / C;
        if (b == 0) return 1'b0;
        if (b <= 8) return mCur[b-1];
        return 1'b1;
    endfunction

    // Per-cycle comparison against the model.
    logic [7:0] actV;
    logic [7:0] expV;
    always @(negedge clk) begin
        if (checkEn) begin
            actV = {tx, busy, level, full, overflow};
            expV = {expTx(), logic'(mActive), 4'(mq.size()), logic'(mq.size() == QS), logic'(mOvf)};
            checks++;
            if (actV !== expV) begin
                errors++;
                $display("FAIL model t=%0t got {tx,busy,level,full,ovf}=%b expected %b", $time, actV, expV);
            end
`ifdef UART_TX_IRQ_EN
            checks++;
            if (tx_empty_irq !== logic'(mIrq)) begin
                errors++;
                $display("FAIL irq t=%0t got %b expected %b", $time, tx_empty_irq, mIrq);
            end
            if (tx_empty_irq === 1'b1) irqCnt++;
`endif
        end
    end

    // Line decoder: recovers bytes from the DUT tx pin by sampling mid-bit.
    logic [7:0] rxQ[$];
    bit         dIn = 0;
    int         dCnt = 0;
    logic [7:0] dByte;
    always @(negedge clk) begin
        if (!dIn) begin
            if (busy === 1'b1 && tx === 1'b0) begin
                dIn = 1;
                dCnt = 0;
            end
        end else if (busy !== 1'b1) begin
            dIn = 0;
        end else begin
            dCnt++;
            if (dCnt >= 6 && dCnt <= 34 && (dCnt % C) == 2) dByte[(dCnt - 6) / C] = tx;
            if (dCnt == FrameLen - 1) begin
                rxQ.push_back(dByte);
                dIn = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [11:0] a, input logic [31:0] d, input logic clr);
        csr_enable = en;
        csr_addr = a;
        csr_data = d;
        overflow_clr = clr;
        @(negedge clk);
        csr_enable = 1'b0;
        csr_addr = '0;
        csr_data = '0;
        overflow_clr = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while ((mActive || mq.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, " drain"}, 32'(n < 3000), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic waitPos(input string name, input int pos);
        int n;
        n = 0;
        while (!(mActive && mPos == pos) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({name, " wait"}, 32'(n < 500), 32'd1);
    endtask

    logic [7:0] exp1[10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    logic [7:0] sent5[$];
    int         busyCnt;
    int         rises;
    logic       prevBusy;
    logic [7:0] b;
    int         r;

    initial begin
        reset = 1'b1;
        csr_enable = 1'b0;
        csr_addr = '0;
        csr_data = '0;
        overflow_clr = 1'b0;
        repeat (3) @(negedge clk);
        checkEn = 1;
        check("reset tx", 32'(tx), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset level", 32'(level), 32'd0);
        check("reset full", 32'(full), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: single byte 0x55
        rxQ.delete();
`ifdef UART_TX_IRQ_EN
        irqCnt = 0;
`endif
        drive(1'b1, 12'h51, 32'h55, 1'b0);
        check("s1 tx high after push edge", 32'(tx), 32'd1);
        check("s1 level after push", 32'(level), 32'd1);
        @(negedge clk);
        check("s1 tx falls", 32'(tx), 32'd0);
        check("s1 busy", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("s1 bit%0d", k), 32'(tx), 32'(exp1[k]));
            if (k < 9) repeat (C) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check("s1 busy end", 32'(busy), 32'd0);
        check("s1 level end", 32'(level), 32'd0);
        waitDrain("s1");
        check("s1 rx count", 32'(rxQ.size()), 32'd1);
        if (rxQ.size() >= 1) check("s1 rx byte", 32'(rxQ[0]), 32'h55);
`ifdef UART_TX_IRQ_EN
        check("s1 irq pulses", 32'(irqCnt), 32'd1);
`endif

        // 2: word 0x44332211, back-to-back frames
        rxQ.delete();
        drive(1'b1, 12'h50, 32'h44332211, 1'b0);
        busyCnt = 0;
        rises = 0;
        prevBusy = busy;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busyCnt++;
            if (busy === 1'b1 && prevBusy !== 1'b1) rises++;
            prevBusy = busy;
        end
        check("s2 busy cycles", 32'(busyCnt), 32'd160);
        check("s2 busy rises", 32'(rises), 32'd1);
        waitDrain("s2");
        check("s2 rx count", 32'(rxQ.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            if (rxQ.size() > k) check($sformatf("s2 rx%0d", k), 32'(rxQ[k]), 32'(8'h11 * (k + 1)));

        // 3: fill to full, overflow and its clear
        drive(1'b1, 12'h50, $urandom, 1'b0);
        drive(1'b1, 12'h50, $urandom, 1'b0);
        drive(1'b1, 12'h51, $urandom, 1'b0);
        check("s3 level full", 32'(level), 32'd8);
        check("s3 full", 32'(full), 32'd1);
        drive(1'b1, 12'h51, $urandom, 1'b0);
        check("s3 overflow set", 32'(overflow), 32'd1);
        check("s3 level kept", 32'(level), 32'd8);
        drive(1'b0, 12'h0, 32'h0, 1'b1);
        check("s3 overflow clr", 32'(overflow), 32'd0);
        drive(1'b1, 12'h51, $urandom, 1'b1);
        check("s3 set beats clr", 32'(overflow), 32'd1);
        drive(1'b0, 12'h0, 32'h0, 1'b1);
        waitDrain("s3");

        // 4: word rejected whole at level 5; byte rejected in the pop cycle at level 8
        drive(1'b1, 12'h50, $urandom, 1'b0);
        drive(1'b1, 12'h51, $urandom, 1'b0);
        drive(1'b1, 12'h51, $urandom, 1'b0);
        check("s4 level5", 32'(level), 32'd5);
        drive(1'b1, 12'h50, $urandom, 1'b0);
        check("s4 word rejected level", 32'(level), 32'd5);
        check("s4 word rejected ovf", 32'(overflow), 32'd1);
        drive(1'b0, 12'h0, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++) drive(1'b1, 12'h51, $urandom, 1'b0);
        check("s4 level8", 32'(level), 32'd8);
        waitPos("s4", FrameLen - 1);
        drive(1'b1, 12'h51, $urandom, 1'b0);
        check("s4 pop-cycle level", 32'(level), 32'd7);
        check("s4 pop-cycle ovf", 32'(overflow), 32'd1);
        drive(1'b1, 12'h51, $urandom, 1'b0);
        check("s4 later accept", 32'(level), 32'd8);
        waitDrain("s4");

        // 5: 12 bytes in bursts across a pointer wrap
        rxQ.delete();
        sent5.delete();
        for (int burst = 0; burst < 3; burst++) begin
            r = 0;
            while (mq.size() > 4 && r < 1000) begin
                @(negedge clk);
                r++;
            end
            for (int k = 0; k < 4; k++) begin
                b = 8'($urandom);
                sent5.push_back(b);
                drive(1'b1, 12'h51, {24'h0, b}, 1'b0);
            end
        end
        waitDrain("s5");
        check("s5 rx count", 32'(rxQ.size()), 32'd12);
        for (int k = 0; k < 12; k++)
            if (rxQ.size() > k) check($sformatf("s5 rx%0d", k), 32'(rxQ[k]), 32'(sent5[k]));

        // Random traffic, including non-queue addresses and stray clears
        rxQ.delete();
        mSent.delete();
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 3);
            csr_enable = ($urandom_range(0, 2) == 0);
            csr_addr = (r == 0) ? 12'h50 : (r == 1) ? 12'h51 : (r == 2) ? 12'($urandom) : 12'h52;
            csr_data = $urandom;
            overflow_clr = ($urandom_range(0, 15) == 0);
            @(negedge clk);
        end
        csr_enable = 1'b0;
        overflow_clr = 1'b0;
        waitDrain("rand");
        check("rand rx count", 32'(rxQ.size()), 32'(mSent.size()));
        for (int k = 0; k < mSent.size(); k++)
            if (rxQ.size() > k) check($sformatf("rand rx%0d", k), 32'(rxQ[k]), 32'(mSent[k]));

        // 6: reset mid-DATA aborts the frame and empties the queue
        rxQ.delete();
        drive(1'b1, 12'h50, $urandom, 1'b0);
        waitPos("s6", 14);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("s6 tx", 32'(tx), 32'd1);
        check("s6 busy", 32'(busy), 32'd0);
        check("s6 level", 32'(level), 32'd0);
        busyCnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) busyCnt++;
        end
        check("s6 no frames", 32'(busyCnt), 32'd0);
        check("s6 rx none", 32'(rxQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
